// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-word memory responder for an instruction or data request port.
// It accepts a read or write request, captures it, waits a fixed latency,
// then raises resp for one cycle. A captured write commits to the internal
// word array on the clock edge that ends the response cycle.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the backing array (power of two)
//   LATENCY      cycles from request capture to resp (1..15)
//   BASE_ADDR    byte address mapped to word 0
//
// Optional build macro:
//   MEM_RESP_RANDOM_STALL_EN  adds 0..3 extra wait cycles per request, taken
//                             from a free-running 16-bit LFSR at capture.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   read     in   read request, held until resp
//   write    in   write request, held until resp
//   address  in   byte address; bits [1:0] ignored
//   wdata    in   write data, byte-lane aligned
//   mbe      in   byte enables, bit i covers wdata[8i+7:8i]
//   rdata    out  read data, valid while resp=1, held otherwise
//   resp     out  one-cycle completion pulse
//   err      out  one-cycle error pulse, coincident with resp
//
// Array contents are not cleared by reset.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for read|write; captures the request when one is seen
// WAIT  | counting down the remaining latency
// RESP  | resp/err asserted for one cycle; a captured write commits here
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  mbe,
    output logic [31:0] rdata,
    output logic        resp,
    output logic        err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] BASE_FULL = BASE_ADDR;
    localparam logic [29:0] BASE_WORD = BASE_FULL[31:2];
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
    localparam logic [4:0]  LAT_M1    = 5'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [4:0]         cnt_load;

    logic [IDX_W-1:0]   req_idx_q, req_idx_d;
    logic               req_inr_q, req_inr_d;
    logic               req_we_q, req_we_d;
    logic               req_both_q, req_both_d;
    logic [31:0]        req_wdata_q, req_wdata_d;
    logic [3:0]         req_mbe_q, req_mbe_d;

    logic [31:0]        rdata_q, rdata_d;
    logic               resp_q, resp_d;
    logic               err_q, err_d;

    logic               enter_resp;
    logic               mem_we;
    logic [31:0]        mem_q [DEPTH_WORDS];

    // Address decode on the live request inputs. Byte offset bits are
    // ignored, so the decode works on word addresses only.
    logic [29:0]        word_off;
    logic               in_range_live;
    logic [IDX_W-1:0]   idx_live;
    logic [1:0]         unused_addr_lsb;

    assign word_off        = address[31:2] - BASE_WORD;
    assign in_range_live   = (address[31:2] >= BASE_WORD) && (word_off < DEPTH_W30);
    assign idx_live        = word_off[IDX_W-1:0];
    assign unused_addr_lsb = address[1:0];

`ifdef MEM_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign cnt_load = LAT_M1 + {3'b000, lfsr_q[1:0]};
`else
    assign cnt_load = LAT_M1;
`endif

    // Next-state and output logic. The *_d request values are the ones the
    // response will be built from, so entering RESP straight from IDLE
    // (zero wait cycles) sees the request being captured on the same edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_idx_d   = req_idx_q;
        req_inr_d   = req_inr_q;
        req_we_d    = req_we_q;
        req_both_d  = req_both_q;
        req_wdata_d = req_wdata_q;
        req_mbe_d   = req_mbe_q;
        rdata_d     = rdata_q;
        resp_d      = 1'b0;
        err_d       = 1'b0;
        enter_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (read || write) begin
                    req_idx_d   = idx_live;
                    req_inr_d   = in_range_live;
                    req_we_d    = write;
                    req_both_d  = read && write;
                    req_wdata_d = wdata;
                    req_mbe_d   = mbe;
                    cnt_d       = cnt_load;
                    if (cnt_load == 5'd0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Counter holds the remaining wait cycles; the last one
                // leaves for RESP as it reaches zero.
                if (cnt_q <= 5'd1) begin
                    cnt_d      = 5'd0;
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            resp_d = 1'b1;
            err_d  = req_both_d || !req_inr_d;
            // Writes (including read+write) leave rdata untouched.
            if (!req_we_d) begin
                rdata_d = req_inr_d ? mem_q[req_idx_d] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            req_idx_q   <= '0;
            req_inr_q   <= 1'b0;
            req_we_q    <= 1'b0;
            req_both_q  <= 1'b0;
            req_wdata_q <= 32'h0;
            req_mbe_q   <= 4'h0;
            rdata_q     <= 32'h0;
            resp_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_idx_q   <= req_idx_d;
            req_inr_q   <= req_inr_d;
            req_we_q    <= req_we_d;
            req_both_q  <= req_both_d;
            req_wdata_q <= req_wdata_d;
            req_mbe_q   <= req_mbe_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    // Commit on the edge that ends RESP; a reset on that edge drops it.
    assign mem_we = (state_q == S_RESP) && req_we_q && req_inr_q && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_mbe_q[b]) begin
                    mem_q[req_idx_q][8*b +: 8] <= req_wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign resp  = resp_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int L     = 2;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic [31:0] rdata;
    logic        resp;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY(L),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .read(read),
        .write(write),
        .address(address),
        .wdata(wdata),
        .mbe(mbe),
        .rdata(rdata),
        .resp(resp),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int lat);
`ifdef MEM_RESP_RANDOM_STALL_EN
        chk(name, 32'((lat >= L) && (lat <= L + 3)), 32'd1);
`else
        chk(name, 32'(lat), 32'(L));
`endif
    endtask

    // One transaction: drive in an IDLE cycle, hold until resp, then drop.
    task automatic xact(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdv, output bit ev, output int lat);
        @(negedge clk);
        read    = rd;
        write   = wr;
        address = a;
        wdata   = wd;
        mbe     = be;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp && lat < 40);
        if (!resp) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got=no_resp exp=resp addr=%h", a);
        end
        rdv   = rdata;
        ev    = err;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
        chk("resp_pulse", {31'b0, resp}, 32'd0);
    endtask

    logic [31:0] mdl [64];

    initial begin
        logic [31:0] rdv;
        bit          ev;
        int          lat;
        int          n;
        bit          saw_resp;
        logic [31:0] last_rd;
        int          nrand;

        rst = 1'b1; read = 1'b0; write = 1'b0;
        address = '0; wdata = '0; mbe = '0;

        // Reset, then idle.
        repeat (2) begin
            @(negedge clk);
            chk("rst_resp", {31'b0, resp}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_resp", {31'b0, resp}, 32'd0);
            chk("idle_err", {31'b0, err}, 32'd0);
            chk("idle_rdata", rdata, 32'd0);
        end

        // Directed vectors.
        vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h20,       32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'h24,       32'hCAFEF00D, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h27,       32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,        32'h22220004, 4'hF, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h1004,     32'h12345678, 4'hF, 32'hCAFEF00D, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h4,        32'h0,        4'h0, 32'h22220004, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFC,      32'h0BADF00D, 4'hF, 32'h22220004, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'hFFC,      32'h0,        4'h0, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0,        32'h11110000, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h8,        32'h88888888, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h8,        32'h0,        4'h0, 32'h88888888, 1'b0});

        foreach (vecs[i]) begin
            xact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, rdv, ev, lat);
            chk($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, ev}, {31'b0, vecs[i].exp_err});
            chk_lat($sformatf("vec%0d_lat", i), lat);
        end

        // Back-to-back: read held, address advanced on the first resp.
        @(negedge clk);
        read = 1'b1; write = 1'b0; address = 32'h0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp && n < 40);
        chk("b2b_first_resp", {31'b0, resp}, 32'd1);
        chk("b2b_first_rdata", rdata, 32'h11110000);
        address = 32'h4;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp && n < 40);
        chk("b2b_second_resp", {31'b0, resp}, 32'd1);
`ifdef MEM_RESP_RANDOM_STALL_EN
        chk("b2b_spacing", 32'((n >= L + 1) && (n <= L + 4)), 32'd1);
`else
        chk("b2b_spacing", 32'(n), 32'(L + 1));
`endif
        chk("b2b_second_rdata", rdata, 32'h22220004);
        read = 1'b0;
        @(negedge clk);

        // Reset in WAIT drops the pending write and suppresses resp.
        @(negedge clk);
        write = 1'b1; read = 1'b0; address = 32'h8; wdata = 32'h55555555; mbe = 4'hF;
        @(negedge clk);
        rst = 1'b1; write = 1'b0;
        saw_resp = resp;
        @(negedge clk);
        rst = 1'b0;
        saw_resp |= resp;
        chk("midrst_rdata", rdata, 32'h0);
        repeat (4) begin
            @(negedge clk);
            saw_resp |= resp;
        end
        chk("midrst_no_resp", {31'b0, saw_resp}, 32'd0);
        xact(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rdv, ev, lat);
        chk("midrst_old_value", rdv, 32'h88888888);

        // Randomized phase against a word-array model.
        for (int w = 0; w < 64; w++) begin
            mdl[w] = $urandom;
            xact(1'b0, 1'b1, 32'(w * 4), mdl[w], 4'hF, rdv, ev, lat);
        end
        xact(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rdv, ev, lat);
        chk("rnd_sync", rdv, mdl[0]);
        last_rd = mdl[0];

`ifdef MEM_RESP_RANDOM_STALL_EN
        nrand = 1000;
`else
        nrand = 200;
`endif
        for (int t = 0; t < nrand; t++) begin
            int          sel;
            bit          rd, wr, inr;
            logic [31:0] a, wd, exp_rd;
            logic [3:0]  be;
            bit          exp_err;
            int          idx;

            sel = $urandom_range(0, 9);
            rd  = (sel <= 3) || (sel == 8) || (sel == 9 && $urandom_range(0, 1) == 1);
            wr  = (sel >= 4 && sel <= 8) || (sel == 9 && !rd);
            if (sel == 9 || $urandom_range(0, 15) == 0)
                a = 32'h1000 + ($urandom_range(0, 4095) << 2) + $urandom_range(0, 3);
            else
                a = ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            wd = $urandom;
            be = 4'($urandom_range(0, 15));

            inr     = a < 32'h1000;
            idx     = int'(a >> 2);
            exp_err = (rd && wr) || !inr;
            if (wr) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
                end
                exp_rd = last_rd;
            end else begin
                exp_rd  = inr ? mdl[idx] : 32'h0;
                last_rd = exp_rd;
            end

            xact(rd, wr, a, wd, be, rdv, ev, lat);
            chk($sformatf("rnd%0d_rdata", t), rdv, exp_rd);
            chk($sformatf("rnd%0d_err", t), {31'b0, ev}, {31'b0, exp_err});
            chk_lat($sformatf("rnd%0d_lat", t), lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
